// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Baud-rate serialiser: pops bytes from the byte FIFO and drives 8N1 frames onto tx, LSB first.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 pop,
  output logic                 active_next,
  output logic                 tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // Popping on the last stop cycle lets the next start bit follow with no idle gap.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  // Lets the top register busy so it lines up with the state this edge produces.
  assign active_next = pop || ((state != IDLE) && !((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= IDLE_LEVEL;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= IDLE_LEVEL;
          if (pop) begin
            shift_reg <= fifo_data;
            tx        <= ~IDLE_LEVEL;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == IDX_LAST) begin
              tx    <= IDLE_LEVEL;
              state <= STOP;
            end else begin
              tx      <= shift_reg[1];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_data;
              tx        <= ~IDLE_LEVEL;
              state     <= START;
            end else begin
              tx    <= IDLE_LEVEL;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte handshake, one-entry hold register and a small FIFO
// in front of the baud-rate serialiser so message bytes leave back-to-back.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] byte_in,
  output logic                 tx,
  output logic                 transmit_done,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  logic                 pending;
  logic                 pending_nxt;
  logic [DATA_BITS-1:0] hold_byte;

  logic                 push;
  logic                 push_new;
  logic                 push_held;
  logic                 hold_load;
  logic [DATA_BITS-1:0] push_data;
  logic                 pop;
  logic                 ser_active_next;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign fifo_data  = fifo_mem[rd_ptr];

  // The held byte may enter on the very edge the serialiser frees a slot, so a
  // full FIFO that is popping this cycle still accepts it.
  assign push_held = pending && (!fifo_full || pop);
  assign push_new  = send && !pending && !fifo_full;
  assign hold_load = send && !pending && fifo_full;
  assign push      = push_held || push_new;
  assign push_data = pending ? hold_byte : byte_in;

  always_comb begin
    pending_nxt = pending;
    if (push_held) begin
      pending_nxt = 1'b0;
    end else if (hold_load) begin
      pending_nxt = 1'b1;
    end

    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pending       <= 1'b0;
      hold_byte     <= '0;
      transmit_done <= 1'b0;
      overflow      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count   <= count_nxt;
      pending <= pending_nxt;
      if (hold_load) begin
        hold_byte <= byte_in;
      end
      // A byte is acknowledged only once it sits in the FIFO, never when merely held.
      transmit_done <= push;
      if (send && pending) begin
        overflow <= 1'b1;
      end
      busy <= pending_nxt || (count_nxt != '0) || ser_active_next;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .pop        (pop),
    .active_next(ser_active_next),
    .tx         (tx)
  );

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: a UART receiver model decodes tx and
// compares each frame against a scoreboard filled as bytes are sent.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       send;
  logic [7:0] byte_in;
  logic       tx;
  logic       transmit_done;
  logic       busy;
  logic       overflow;

  int         checks = 0;
  int         passes = 0;
  int         cycle = 0;
  int         done_count = 0;
  int         frame_count = 0;
  int         frame_starts[$];
  logic [7:0] sb[$];
  int         last_send_cycle = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .send         (send),
    .byte_in      (byte_in),
    .tx           (tx),
    .transmit_done(transmit_done),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (transmit_done === 1'b1) done_count <= done_count + 1;
  end

  // Receiver model: start seen at negedge of cycle s, bits sampled mid-bit.
  initial begin : rx_monitor
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    logic       start_ok;
    logic       stop_ok;
    bit         aborted;
    int         s;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && tx === 1'b0) begin
        s = cycle;
        rx_byte = '0;
        start_ok = 1'b0;
        stop_ok = 1'b0;
        aborted = 1'b0;
        for (int c = 1; c <= 38 && !aborted; c++) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            aborted = 1'b1;
          end else begin
            if (c == 2) start_ok = (tx === 1'b0);
            if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) rx_byte[(c-6)/4] = tx;
            if (c == 38) stop_ok = (tx === 1'b1);
          end
        end
        if (!aborted) begin
          frame_count++;
          frame_starts.push_back(s);
          checks++;
          if (sb.size() == 0) begin
            $display("[TB] FAIL rx_unexpected_frame: got byte %h at cycle %0d, required no frame", rx_byte, s);
          end else begin
            exp_byte = sb.pop_front();
            if (rx_byte !== exp_byte)
              $display("[TB] FAIL rx_byte: got %h, required %h (frame at cycle %0d)", rx_byte, exp_byte, s);
            else
              passes++;
          end
          checks++;
          if (!(start_ok && stop_ok))
            $display("[TB] FAIL rx_framing: start_ok=%b stop_ok=%b, required 1 1", start_ok, stop_ok);
          else
            passes++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_send(input logic [7:0] b, input bit expect_accept);
    @(posedge clk); #1;
    send = 1'b1;
    byte_in = b;
    last_send_cycle = cycle;
    if (expect_accept) sb.push_back(b);
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    bit seen = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (transmit_done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cycle;
      end
    end
    checks++;
    if (!seen) $display("[TB] FAIL handshake_timeout: transmit_done=0 for 200 cycles, required 1");
    else passes++;
  endtask

  task automatic send_hs(input logic [7:0] b, output int done_cyc);
    drive_send(b, 1'b1);
    wait_done(done_cyc);
  endtask

  task automatic wait_idle(output int idle_cyc);
    bit seen = 1'b0;
    idle_cyc = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        seen = 1'b1;
        idle_cyc = cycle;
      end
    end
    checks++;
    if (!seen) $display("[TB] FAIL idle_timeout: busy=1 for 2000 cycles, required 0");
    else passes++;
  endtask

  task automatic wait_frames(input int target, input int bound);
    for (int i = 0; i < bound && frame_count < target; i++) @(posedge clk);
    checks++;
    if (frame_count < target)
      $display("[TB] FAIL frames_timeout: got %0d frames, required %0d", frame_count, target);
    else
      passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send = 1'b0;
    byte_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b, required 1", tx); else passes++;
    checks++; if (transmit_done !== 1'b0) $display("[TB] FAIL reset_done: got %b, required 0", transmit_done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, required 0", busy); else passes++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b, required 0", overflow); else passes++;
  endtask

  task automatic test_single();
    logic [9:0] frame_bits;
    int base_done;
    int base_frames;
    int err;
    int idle;
    frame_bits = {1'b1, 8'hA5, 1'b0};
    base_done = done_count;
    base_frames = frame_count;
    @(posedge clk); #1;
    send = 1'b1;
    byte_in = 8'hA5;
    sb.push_back(8'hA5);
    @(negedge clk);
    checks++; if (transmit_done !== 1'b0) $display("[TB] FAIL single_done_c0: got %b, required 0", transmit_done); else passes++;
    @(posedge clk); #1 send = 1'b0;
    @(negedge clk);
    checks++; if (transmit_done !== 1'b1) $display("[TB] FAIL single_done_c1: got %b, required 1", transmit_done); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_c1: got %b, required 1", busy); else passes++;
    for (int b = 0; b < 10; b++) begin
      err = 0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (tx !== frame_bits[b]) err++;
      end
      checks++;
      if (err != 0) $display("[TB] FAIL single_tx_bit%0d: %0d cycles wrong, tx=%b, required %b", b, err, tx, frame_bits[b]);
      else passes++;
    end
    checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_c41: got %b, required 1", busy); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_c42: got %b, required 0", busy); else passes++;
    wait_frames(base_frames + 1, 100);
    wait_idle(idle);
    repeat (2) @(negedge clk);
    checks++;
    if (done_count - base_done != 1) $display("[TB] FAIL single_pulse_count: got %0d, required 1", done_count - base_done);
    else passes++;
  endtask

  task automatic test_pair();
    int base_done;
    int base_frames;
    int d1;
    int d2;
    int idle;
    wait_idle(idle);
    base_done = done_count;
    base_frames = frame_count;
    send_hs(8'hE0, d1);
    send_hs(8'h16, d2);
    wait_frames(base_frames + 2, 300);
    wait_idle(idle);
    repeat (2) @(negedge clk);
    checks++;
    if (done_count - base_done != 2) $display("[TB] FAIL pair_pulses: got %0d, required 2", done_count - base_done);
    else passes++;
    if (frame_starts.size() >= base_frames + 2) begin
      checks++;
      if (frame_starts[base_frames+1] - frame_starts[base_frames] != 40)
        $display("[TB] FAIL pair_gap: got %0d cycles between starts, required 40",
                 frame_starts[base_frames+1] - frame_starts[base_frames]);
      else passes++;
      checks++;
      if (idle - frame_starts[base_frames] != 80)
        $display("[TB] FAIL pair_total: got %0d cycles, required 80", idle - frame_starts[base_frames]);
      else passes++;
    end
  endtask

  task automatic test_fill();
    int base_frames;
    int dc;
    int d6;
    int d7;
    int idle;
    wait_idle(idle);
    base_frames = frame_count;
    for (int i = 0; i < 5; i++) send_hs(8'h31 + 8'(i), dc);
    drive_send(8'h36, 1'b1);
    @(negedge clk);
    checks++;
    if (dut.pending !== 1'b1 || transmit_done !== 1'b0)
      $display("[TB] FAIL fill_pending: pending=%b done=%b, required 1 0", dut.pending, transmit_done);
    else passes++;
    wait_done(d6);
    send_hs(8'h37, d7);
    wait_frames(base_frames + 7, 7 * 40 + 100);
    if (frame_starts.size() >= base_frames + 3) begin
      checks++;
      if (d6 != frame_starts[base_frames+1])
        $display("[TB] FAIL fill_held_done6: got cycle %0d, required %0d", d6, frame_starts[base_frames+1]);
      else passes++;
      checks++;
      if (d7 != frame_starts[base_frames+2])
        $display("[TB] FAIL fill_held_done7: got cycle %0d, required %0d", d7, frame_starts[base_frames+2]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    int base_done;
    int base_frames;
    int dc;
    int idle;
    wait_idle(idle);
    base_done = done_count;
    base_frames = frame_count;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL overflow_before: got %b, required 0", overflow); else passes++;
    for (int i = 0; i < 5; i++) send_hs(8'h41 + 8'(i), dc);
    @(posedge clk); #1;
    send = 1'b1;
    byte_in = 8'h11;
    sb.push_back(8'h11);
    @(posedge clk); #1;
    byte_in = 8'h22;
    @(posedge clk); #1;
    send = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) $display("[TB] FAIL overflow_set: got %b, required 1", overflow); else passes++;
    wait_frames(base_frames + 6, 6 * 40 + 100);
    wait_idle(idle);
    repeat (40) @(negedge clk);
    checks++; if (overflow !== 1'b1) $display("[TB] FAIL overflow_sticky: got %b, required 1", overflow); else passes++;
    checks++;
    if (frame_count - base_frames != 6) $display("[TB] FAIL overflow_frames: got %0d, required 6", frame_count - base_frames);
    else passes++;
    checks++;
    if (done_count - base_done != 6) $display("[TB] FAIL overflow_pulses: got %0d, required 6", done_count - base_done);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int base_frames;
    int base_done;
    int t0;
    int dc;
    int err;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_clears_overflow: got %b, required 0", overflow); else passes++;
    send_hs(8'h5A, dc);
    t0 = last_send_cycle;
    send_hs(8'hC3, dc);
    send_hs(8'h3C, dc);
    repeat (t0 + 17 - cycle) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) $display("[TB] FAIL midreset_tx: got %b, required 1", tx); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b, required 0", busy); else passes++;
    checks++; if (transmit_done !== 1'b0) $display("[TB] FAIL midreset_done: got %b, required 0", transmit_done); else passes++;
    base_frames = frame_count;
    @(negedge clk);
    base_done = done_count;
    err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) err++;
    end
    checks++; if (err != 0) $display("[TB] FAIL midreset_line_idle: %0d active cycles, required 0", err); else passes++;
    checks++;
    if (frame_count != base_frames) $display("[TB] FAIL midreset_frames: got %0d, required %0d", frame_count, base_frames);
    else passes++;
    checks++;
    if (done_count != base_done) $display("[TB] FAIL midreset_pulses: got %0d, required %0d", done_count, base_done);
    else passes++;
  endtask

  task automatic test_wrap();
    int base_frames;
    int dc;
    int idle;
    wait_idle(idle);
    base_frames = frame_count;
    for (int i = 0; i < 10; i++) send_hs(8'(i), dc);
    wait_frames(base_frames + 10, 10 * 40 + 200);
    wait_idle(idle);
    checks++;
    if (frame_count - base_frames != 10) $display("[TB] FAIL wrap_frames: got %0d, required 10", frame_count - base_frames);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    send = 1'b0;
    byte_in = '0;
    test_reset();
    test_single();
    test_pair();
    test_fill();
    test_overflow();
    test_reset_mid();
    test_wrap();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) $display("[TB] FAIL scoreboard_drained: %0d bytes never sent, required 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
